// File: rtl/pacman_pkg.sv
// Shared types for the pacman sprite datapath: headings, mover states, colours.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_U = 2'd1,
    DIR_R = 2'd2,
    DIR_D = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_INI,
    ST_STILL,
    ST_MOVE,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_YELLOW = 12'hFF0;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_L:   return DIR_R;
      DIR_U:   return DIR_D;
      DIR_R:   return DIR_L;
      default: return DIR_U;
    endcase
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Free-running divider: one-clock tick every TICK_DIV clocks, on the last count.
// Runs in every state; no backpressure; reset restarts the phase at 0.
module move_tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/sprite_mover.sv
// Tile-grid player mover: turns and stops at tile centres, buffers one turn request, optional tunnels.
// Position/dir/state update on the move tick, visible next cycle; fill/rgb are combinational.
module sprite_mover
  import pacman_pkg::*;
#(
  parameter int          TILE_W   = 8,
  parameter int          GRID_X   = 80,
  parameter int          GRID_Y   = 60,
  parameter int          STEP     = 1,
  parameter int          TICK_DIV = 250000,
  parameter int          SPRITE   = 5,
  parameter int          X_INI    = 37,
  parameter int          Y_INI    = 37,
  parameter bit          WRAP_EN  = 1'b1,
  parameter logic [11:0] COLOR    = RGB_YELLOW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  input  logic        win,
  input  logic        lose,
  input  logic [3:0]  dir_req,
  input  logic        wall_l,
  input  logic        wall_u,
  input  logic        wall_r,
  input  logic        wall_d,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        bright,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic [6:0]  tile_x,
  output logic [6:0]  tile_y,
  output logic [1:0]  dir,
  output logic        moving,
  output logic        fill,
  output logic [11:0] rgb
);

  localparam logic [9:0] TW     = 10'(TILE_W);
  localparam logic [9:0] HALF_T = 10'(TILE_W / 2);
  localparam logic [9:0] STP    = 10'(STEP);
  localparam logic [9:0] ROW_W  = 10'(GRID_X * TILE_W);
  localparam logic [9:0] COL_H  = 10'(GRID_Y * TILE_W);
  localparam logic [9:0] X0     = 10'(X_INI * TILE_W + TILE_W / 2);
  localparam logic [9:0] Y0     = 10'(Y_INI * TILE_W + TILE_W / 2);
  localparam logic [9:0] SPR_H  = 10'(SPRITE / 2);

  // A 1024-wide row makes ROW_W wrap to 0, which the mod-1024 arithmetic below still handles.
  function automatic logic [19:0] step_pos(input logic [9:0] x, input logic [9:0] y, input dir_t d);
    logic [9:0] nx;
    logic [9:0] ny;
    nx = x;
    ny = y;
    case (d)
      DIR_L: if (x >= STP) nx = x - STP; else if (WRAP_EN) nx = x + ROW_W - STP;
      DIR_R: if (x < ROW_W - STP) nx = x + STP; else if (WRAP_EN) nx = x + STP - ROW_W;
      DIR_U: if (y >= STP) ny = y - STP;
      DIR_D: if (y < COL_H - STP) ny = y + STP;
    endcase
    return {nx, ny};
  endfunction

  state_t     state, state_n;
  dir_t       dir_q, dir_n, go_dir, req_dir, pend_dir, pend_dir_n;
  logic       pend_vld, pend_vld_n, req_vld, go, tick, at_ctr;
  logic [9:0] px_n, py_n, dx, dy;
  logic [3:0] walls;

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign walls  = {wall_d, wall_r, wall_u, wall_l};
  assign at_ctr = (pos_x % TW == HALF_T) && (pos_y % TW == HALF_T);

  always_comb begin
    req_vld = 1'b1;
    req_dir = DIR_L;
    case (dir_req)
      4'b1000: req_dir = DIR_L;
      4'b0100: req_dir = DIR_U;
      4'b0010: req_dir = DIR_R;
      4'b0001: req_dir = DIR_D;
      default: req_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    dir_n      = dir_q;
    pend_vld_n = pend_vld;
    pend_dir_n = pend_dir;
    px_n       = pos_x;
    py_n       = pos_y;
    go         = 1'b0;
    go_dir     = dir_q;
    case (state)
      ST_INI: begin
        px_n       = X0;
        py_n       = Y0;
        dir_n      = DIR_L;
        pend_vld_n = 1'b0;
        if (start) state_n = ST_STILL;
      end
      ST_STILL, ST_MOVE: begin
        if (win)       state_n = ST_WIN;
        else if (lose) state_n = ST_LOSE;
        else if (tick) begin
          if (at_ctr) begin
            if (pend_vld && !walls[pend_dir]) begin
              dir_n      = pend_dir;
              go_dir     = pend_dir;
              pend_vld_n = 1'b0;
              state_n    = ST_MOVE;
              go         = 1'b1;
            end else if (state == ST_MOVE && !walls[dir_q]) begin
              go = 1'b1;
            end else begin
              state_n = ST_STILL;
            end
          end else if (state == ST_MOVE) begin
            // Mid-tile only a reversal may be taken; other turns wait for the centre.
            if (pend_vld && pend_dir == opposite(dir_q)) begin
              dir_n      = opposite(dir_q);
              go_dir     = opposite(dir_q);
              pend_vld_n = 1'b0;
            end
            go = 1'b1;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (ack) begin
          state_n    = ST_INI;
          px_n       = X0;
          py_n       = Y0;
          dir_n      = DIR_L;
          pend_vld_n = 1'b0;
        end
      end
      default: state_n = ST_INI;
    endcase
    if (go) {px_n, py_n} = step_pos(pos_x, pos_y, go_dir);
    // A fresh request overrides a same-cycle consume, so it is used at the following tick.
    if (req_vld && state != ST_INI) begin
      pend_vld_n = 1'b1;
      pend_dir_n = req_dir;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INI;
      dir_q    <= DIR_L;
      pend_vld <= 1'b0;
      pend_dir <= DIR_L;
      pos_x    <= X0;
      pos_y    <= Y0;
    end else begin
      state    <= state_n;
      dir_q    <= dir_n;
      pend_vld <= pend_vld_n;
      pend_dir <= pend_dir_n;
      pos_x    <= px_n;
      pos_y    <= py_n;
    end
  end

  assign dir    = dir_q;
  assign moving = (state == ST_MOVE);
  assign tile_x = 7'(pos_x / TW);
  assign tile_y = 7'(pos_y / TW);

  assign dx   = (hCount >= pos_x) ? hCount - pos_x : pos_x - hCount;
  assign dy   = (vCount >= pos_y) ? vCount - pos_y : pos_y - vCount;
  assign fill = (dx <= SPR_H) && (dy <= SPR_H);
  assign rgb  = (bright && fill) ? COLOR : RGB_BLACK;

endmodule
